// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types used by the MEM stage.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: inserts a bubble while the MEM stage stalls,
// otherwise forwards the *_M fields and captures load data on completion.
module mem_wb_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              kill,
  input  logic              misalign,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              RegWrite_M,
  input  logic              MemToReg_M,
  input  logic [DATA_W-1:0] ALUout_M,
  input  logic [REG_W-1:0]  WriteReg_M,
  output logic              RegWrite_W,
  output logic              MemToReg_W,
  output logic [DATA_W-1:0] ReadData_W,
  output logic [DATA_W-1:0] ALUout_W,
  output logic [REG_W-1:0]  WriteReg_W,
  output logic              MisAlign_W
);

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_W <= 1'b0;
      MemToReg_W <= 1'b0;
      ReadData_W <= '0;
      ALUout_W   <= '0;
      WriteReg_W <= '0;
      MisAlign_W <= 1'b0;
    end else if (stall) begin
      // Bubble: only the write enable and the flag are cleared, data fields hold.
      RegWrite_W <= 1'b0;
      MisAlign_W <= 1'b0;
    end else begin
      RegWrite_W <= RegWrite_M & ~kill;
      MemToReg_W <= MemToReg_M;
      ALUout_W   <= ALUout_M;
      WriteReg_W <= WriteReg_M;
      MisAlign_W <= misalign;
      if (ld_valid) ReadData_W <= ld_data;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: req/ack data-memory bus master with stall and alignment check.
// Optional ack timeout with BusErr_W output enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_W   = mips_pkg::REG_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_M,
  input  logic              MemToReg_M,
  input  logic              MemWrite_M,
  input  logic              MemRead_M,
  input  logic [DATA_W-1:0] ALUout_M,
  input  logic [DATA_W-1:0] WriteData_M,
  input  logic [REG_W-1:0]  WriteReg_M,
  output logic              Stall_M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              RegWrite_W,
  output logic              MemToReg_W,
  output logic [DATA_W-1:0] ReadData_W,
  output logic [DATA_W-1:0] ALUout_W,
  output logic [REG_W-1:0]  WriteReg_W,
  output logic              MisAlign_W
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              BusErr_W
`endif
);

  state_t state, state_nxt;
  logic   mem_op, aligned, start, ack_b, tmo, done, misalign;

  always_comb begin
    mem_op   = MemRead_M | MemWrite_M;
    aligned  = (ALUout_M[1:0] & ALIGN_MASK) == 2'b00;
    start    = (state == IDLE) && mem_op && aligned;
    misalign = (state == IDLE) && mem_op && !aligned;
    ack_b    = (state == BUSY) && dmem_ack;
    done     = ack_b | tmo;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || start)                 cnt <= '0;
    else if (state == BUSY && !done)  cnt <= cnt + CNT_W'(1);
  end

  assign tmo = (state == BUSY) && !dmem_ack && (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) BusErr_W <= 1'b0;
    else     BusErr_W <= tmo;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo            = 1'b0;
`endif

  assign Stall_M = start | ((state == BUSY) && !done);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: if (done)  state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= MemWrite_M;
        dmem_addr  <= ALUout_M;
        dmem_wdata <= WriteData_M;
      end else if (done) begin
        dmem_req <= 1'b0;
      end
    end
  end

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_mem_wb_reg (
    .clk       (clk),
    .rst       (rst),
    .stall     (Stall_M),
    .kill      (misalign | tmo),
    .misalign  (misalign),
    .ld_valid  (done),
    .ld_data   (tmo ? '0 : dmem_rdata),
    .RegWrite_M(RegWrite_M),
    .MemToReg_M(MemToReg_M),
    .ALUout_M  (ALUout_M),
    .WriteReg_M(WriteReg_M),
    .RegWrite_W(RegWrite_W),
    .MemToReg_W(MemToReg_W),
    .ReadData_W(ReadData_W),
    .ALUout_W  (ALUout_W),
    .WriteReg_W(WriteReg_W),
    .MisAlign_W(MisAlign_W)
  );

endmodule
